// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit holding the HI/LO pair.
// One bit per cycle: shift-add multiply, restoring divide.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DZ
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]      r_cnt;
  logic               r_div;
  logic               r_sa;
  logic               r_sb;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz;

  logic               w_sgn;
  logic               w_dz;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_accept;
  logic               w_mtx;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_div_nxt;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo_f;
  logic [WIDTH-1:0]   w_rem_f;

  // op[0]=0 selects the signed flavour; op[1]=1 selects divide
  assign w_sgn    = ~op[0];
  assign w_dz     = op[1] & (op_b == '0);
  assign w_neg_a  = w_sgn & op_a[WIDTH-1];
  assign w_neg_b  = w_sgn & op_b[WIDTH-1];
  assign w_mag_a  = w_neg_a ? -op_a : op_a;
  assign w_mag_b  = w_neg_b ? -op_b : op_b;
  assign w_accept = (r_state == IDLE) & start;
  assign w_mtx    = (r_state == IDLE) & ~start;

  // multiply: add multiplicand on LSB, shift right with carry
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
  assign w_mul_nxt = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                              : {1'b0, r_acc[2*WIDTH-1:1]};

  // divide: upper half is partial remainder, lower half dividend/quotient
  assign w_shl     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff    = w_shl - {1'b0, r_b};
  assign w_rem     = w_diff[WIDTH] ? w_shl[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_div_nxt = {w_rem, r_acc[WIDTH-2:0], ~w_diff[WIDTH]};

  assign w_prod  = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo_f = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_f = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_dz ? DZ : CALC;
      CALC:    if (r_cnt == '0) w_next = FIX;
      FIX:     w_next = IDLE;
      DZ:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // operand latch and one iteration per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_div <= 1'b0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (w_accept && !w_dz) begin
      r_cnt <= CW'(WIDTH - 1);
      r_div <= op[1];
      r_sa  <= w_neg_a;
      r_sb  <= w_neg_b;
      r_a   <= w_mag_a;
      r_b   <= w_mag_b;
      r_acc <= op[1] ? {{WIDTH{1'b0}}, w_mag_a}
                     : {{WIDTH{1'b0}}, w_mag_b};
    end else if (r_state == CALC) begin
      r_acc <= r_div ? w_div_nxt : w_mul_nxt;
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
    end
  end

  // HI/LO: sign-corrected result on FIX, mthi/mtlo only when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == FIX) begin
      r_hi <= r_div ? w_rem_f : w_prod[2*WIDTH-1:WIDTH];
      r_lo <= r_div ? w_quo_f : w_prod[WIDTH-1:0];
    end else if (w_mtx) begin
      if (hi_wr) r_hi <= wr_data;
      if (lo_wr) r_lo <= wr_data;
    end
  end

  // completion pulses, registered off the final state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= (r_state == FIX) | (r_state == DZ);
      r_dbz  <= (r_state == DZ);
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
